// File: rtl/font_pkg.sv
// Shared constants, FSM encoding and bit helper for the font glyph sequencer.
package font_pkg;

   localparam int GLYPH_ROWS = 16;
   localparam int GLYPH_COLS = 16;
   localparam int ROM_AW     = 8;
   localparam int ROM_DW     = 16;
   localparam int CNT_W      = 4;
   localparam int GLYPH_W    = ROM_AW - CNT_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Mirror a ROM word so that column 0 always sits in the MSB.
   function automatic logic [ROM_DW-1:0] bit_reverse(input logic [ROM_DW-1:0] d);
      logic [ROM_DW-1:0] r;
      for (int i = 0; i < ROM_DW; i++) begin
         r[i] = d[ROM_DW-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/font_row_shifter.sv
// Row shift register: holds one font ROM row and presents one pixel per column.
module font_row_shifter
   import font_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1,
   parameter bit INVERT    = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [ROM_DW-1:0] data_i,
   output logic              pixel_o
);

   logic [ROM_DW-1:0] norm_d;
   logic [ROM_DW-1:0] row_q;
   logic              pixel_q;

   // Normalise ROM bit order so the next column is always taken from the MSB.
   always_comb begin
      norm_d = MSB_FIRST ? data_i : bit_reverse(data_i);
   end

   // Pixel is its own register so reset gives 0 regardless of INVERT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q   <= '0;
         pixel_q <= 1'b0;
      end else if (load_i) begin
         pixel_q <= norm_d[ROM_DW-1] ^ INVERT;
         row_q   <= {norm_d[ROM_DW-2:0], 1'b0};
      end else if (shift_i) begin
         pixel_q <= row_q[ROM_DW-1] ^ INVERT;
         row_q   <= {row_q[ROM_DW-2:0], 1'b0};
      end
   end

   assign pixel_o = pixel_q;

endmodule

// File: rtl/font_glyph_sequencer.sv
// Walks a 16x16 glyph row by row from a combinational font ROM and streams
// its pixels out over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start_i; glyph index latched on acceptance
//   FETCH | ROM address stable, row data loaded at the closing edge
//   SHIFT | pixel valid; advances one column per accepted pixel
//   DONE  | one-cycle completion pulse, then back to IDLE
module font_glyph_sequencer
   import font_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1,
   parameter bit INVERT    = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [GLYPH_W-1:0] glyph_i,
   input  logic               abort_i,
   output logic               busy_o,
   output logic [ROM_AW-1:0]  rom_address_o,
   input  logic [ROM_DW-1:0]  rom_data_i,
   output logic               pix_valid_o,
   input  logic               pix_ready_i,
   output logic               pixel_o,
   output logic [CNT_W-1:0]   pix_x_o,
   output logic [CNT_W-1:0]   pix_y_o,
   output logic               done_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(GLYPH_COLS - 1);

   state_t              state_q;
   logic [GLYPH_W-1:0]  glyph_q;
   logic [CNT_W-1:0]    row_q;
   logic [CNT_W-1:0]    col_q;
   logic [CNT_W-1:0]    row_nxt;
   logic [ROM_AW-1:0]   rom_addr_q;
   logic                busy_q;
   logic                pix_valid_q;
   logic                done_q;
   logic                load_row;
   logic                shift_en;

   assign row_nxt  = row_q + 4'd1;
   assign load_row = (state_q == FETCH) && !abort_i;
   assign shift_en = (state_q == SHIFT) && pix_ready_i && !abort_i;

   // Sequencer FSM with registered outputs; abort overrides every transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         glyph_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         rom_addr_q  <= '0;
         busy_q      <= 1'b0;
         pix_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i) begin
                     glyph_q    <= glyph_i;
                     row_q      <= '0;
                     rom_addr_q <= {glyph_i, 4'h0};
                     busy_q     <= 1'b1;
                     state_q    <= FETCH;
                  end
               end
               FETCH: begin
                  col_q       <= '0;
                  pix_valid_q <= 1'b1;
                  state_q     <= SHIFT;
               end
               SHIFT: begin
                  if (pix_ready_i) begin
                     if (col_q == LAST) begin
                        pix_valid_q <= 1'b0;
                        if (row_q == LAST) begin
                           row_q   <= '0;
                           col_q   <= '0;
                           done_q  <= 1'b1;
                           state_q <= DONE;
                        end else begin
                           row_q      <= row_nxt;
                           rom_addr_q <= {glyph_q, row_nxt};
                           state_q    <= FETCH;
                        end
                     end else begin
                        col_q <= col_q + 4'd1;
                     end
                  end
               end
               DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   font_row_shifter #(
      .MSB_FIRST (MSB_FIRST),
      .INVERT    (INVERT)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_row),
      .shift_i (shift_en),
      .data_i  (rom_data_i),
      .pixel_o (pixel_o)
   );

   assign busy_o        = busy_q;
   assign rom_address_o = rom_addr_q;
   assign pix_valid_o   = pix_valid_q;
   assign pix_x_o       = col_q;
   assign pix_y_o       = row_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_font_glyph_sequencer.sv
// Directed bench for font_glyph_sequencer: default instance plus an
// LSB-first / inverted instance, each fed by a constant-row ROM model.
module tb_font_glyph_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start_i = 1'b0;
   logic [3:0]  glyph_i = '0;
   logic        abort_i = 1'b0;
   logic        busy_o;
   logic [7:0]  rom_address_o;
   logic [15:0] rom_data_i;
   logic        pix_valid_o;
   logic        pix_ready_i = 1'b0;
   logic        pixel_o;
   logic [3:0]  pix_x_o;
   logic [3:0]  pix_y_o;
   logic        done_o;

   logic        start2 = 1'b0;
   logic [3:0]  glyph2 = '0;
   logic        abort2 = 1'b0;
   logic        busy2;
   logic [7:0]  addr2;
   logic [15:0] data2;
   logic        valid2;
   logic        ready2 = 1'b0;
   logic        pixel2;
   logic [3:0]  x2;
   logic [3:0]  y2;
   logic        done2;

   int tests = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign rom_data_i = 16'hA5C3;
   assign data2      = 16'h0001;

   font_glyph_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .glyph_i       (glyph_i),
      .abort_i       (abort_i),
      .busy_o        (busy_o),
      .rom_address_o (rom_address_o),
      .rom_data_i    (rom_data_i),
      .pix_valid_o   (pix_valid_o),
      .pix_ready_i   (pix_ready_i),
      .pixel_o       (pixel_o),
      .pix_x_o       (pix_x_o),
      .pix_y_o       (pix_y_o),
      .done_o        (done_o)
   );

   font_glyph_sequencer #(.MSB_FIRST(1'b0), .INVERT(1'b1)) dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start2),
      .glyph_i       (glyph2),
      .abort_i       (abort2),
      .busy_o        (busy2),
      .rom_address_o (addr2),
      .rom_data_i    (data2),
      .pix_valid_o   (valid2),
      .pix_ready_i   (ready2),
      .pixel_o       (pixel2),
      .pix_x_o       (x2),
      .pix_y_o       (y2),
      .done_o        (done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},  32'(busy_o),        32'd0);
      chk({tag, "_valid"}, 32'(pix_valid_o),   32'd0);
      chk({tag, "_done"},  32'(done_o),        32'd0);
      chk({tag, "_pixel"}, 32'(pixel_o),       32'd0);
      chk({tag, "_x"},     32'(pix_x_o),       32'd0);
      chk({tag, "_y"},     32'(pix_y_o),       32'd0);
      chk({tag, "_addr"},  32'(rom_address_o), 32'd0);
   endtask

   // Render one glyph on dut. mode 0: ready held high; mode 1: ready toggles.
   // inject: pulse start during SHIFT (with another glyph) and during DONE.
   task automatic run_glyph(input logic [3:0] g, input int mode, input logic [15:0] row_bits,
                            input bit inject);
      int  n = 0;
      int  k = 0;
      int  first_valid = -1;
      bit  stalled;
      logic       s_pix;
      logic [3:0] s_x, s_y;
      logic [3:0] col;
      logic [3:0] row;

      glyph_i = g;
      start_i = 1'b1;
      pix_ready_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("start_busy", 32'(busy_o), 32'd1);
      chk("start_addr", 32'(rom_address_o), 32'({g, 4'h0}));
      chk("start_valid", 32'(pix_valid_o), 32'd0);

      while (!done_o && n < 700) begin
         pix_ready_i = (mode == 0) ? 1'b1 : (n % 2 == 0);
         start_i = (inject && k == 40) ? 1'b1 : 1'b0;
         if (inject && k == 40) glyph_i = 4'd9;
         stalled = 1'b0;
         col = 4'(k % 16);
         row = 4'(k / 16);
         if (pix_valid_o) begin
            if (first_valid < 0) first_valid = n;
            if (pix_ready_i) begin
               chk("pix_value", 32'(pixel_o), 32'(row_bits[15 - int'(col)]));
               chk("pix_x", 32'(pix_x_o), 32'(col));
               chk("pix_y", 32'(pix_y_o), 32'(row));
               k++;
            end else begin
               stalled = 1'b1;
               s_pix = pixel_o;
               s_x = pix_x_o;
               s_y = pix_y_o;
            end
         end else begin
            chk("fetch_addr", 32'(rom_address_o), 32'({g, row}));
            chk("fetch_busy", 32'(busy_o), 32'd1);
         end
         step();
         n++;
         if (stalled) begin
            chk("stall_valid", 32'(pix_valid_o), 32'd1);
            chk("stall_pixel", 32'(pixel_o), 32'(s_pix));
            chk("stall_x", 32'(pix_x_o), 32'(s_x));
            chk("stall_y", 32'(pix_y_o), 32'(s_y));
         end
      end
      start_i = 1'b0;

      chk("done_seen", 32'(done_o), 32'd1);
      chk("pixel_count", 32'(k), 32'd256);
      chk("first_pixel_latency", 32'(first_valid), 32'd1);
      // Done is seen in the 273rd cycle counting the first FETCH as cycle 1.
      if (mode == 0) chk("done_latency", 32'(n), 32'd272);
      chk("done_busy", 32'(busy_o), 32'd1);
      chk("done_valid", 32'(pix_valid_o), 32'd0);

      if (inject) begin
         start_i = 1'b1;
         glyph_i = 4'd9;
      end
      step();
      start_i = 1'b0;
      chk("post_done_pulse", 32'(done_o), 32'd0);
      chk("post_done_busy", 32'(busy_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_hold_busy", 32'(busy_o), 32'd0);
         chk("idle_hold_done", 32'(done_o), 32'd0);
      end
   endtask

   initial begin
      bit found;

      // Reset state
      #3;
      check_reset_outputs("reset");
      chk("reset_busy2", 32'(busy2), 32'd0);
      chk("reset_pixel2", 32'(pixel2), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("idle_after_reset", 32'(busy_o), 32'd0);

      // Full glyph, ready held high
      run_glyph(4'd3, 0, 16'hA5C3, 1'b0);

      // Full glyph, ready toggling
      run_glyph(4'd3, 1, 16'hA5C3, 1'b0);

      // LSB-first, inverted instance with row 16'h0001
      glyph2 = 4'd0;
      start2 = 1'b1;
      ready2 = 1'b1;
      step();
      start2 = 1'b0;
      chk("inv_start_busy", 32'(busy2), 32'd1);
      chk("inv_start_addr", 32'(addr2), 32'h00);
      step();
      for (int c = 0; c < 16; c++) begin
         chk("inv_valid", 32'(valid2), 32'd1);
         chk("inv_pixel", 32'(pixel2), (c == 0) ? 32'd0 : 32'd1);
         chk("inv_x", 32'(x2), 32'(c));
         step();
      end
      chk("inv_fetch_addr", 32'(addr2), 32'h01);
      chk("inv_fetch_valid", 32'(valid2), 32'd0);
      abort2 = 1'b1;
      step();
      abort2 = 1'b0;
      chk("inv_abort_busy", 32'(busy2), 32'd0);

      // Abort at row 7, col 9
      glyph_i = 4'd1;
      pix_ready_i = 1'b1;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (pix_valid_o && pix_y_o == 4'd7 && pix_x_o == 4'd9) found = 1'b1;
         else step();
      end
      chk("abort_reach", 32'(found), 32'd1);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_valid", 32'(pix_valid_o), 32'd0);
      chk("abort_done", 32'(done_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_idle_busy", 32'(busy_o), 32'd0);
         chk("abort_idle_done", 32'(done_o), 32'd0);
      end

      // Abort together with Start in IDLE stays idle
      glyph_i = 4'd5;
      start_i = 1'b1;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      start_i = 1'b0;
      chk("abort_start_busy", 32'(busy_o), 32'd0);

      // New glyph after abort
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("restart_busy", 32'(busy_o), 32'd1);
      chk("restart_addr", 32'(rom_address_o), 32'h50);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("restart_abort_busy", 32'(busy_o), 32'd0);

      // Asynchronous reset mid-glyph at row 2
      glyph_i = 4'd2;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (pix_valid_o && pix_y_o == 4'd2 && pix_x_o == 4'd4) found = 1'b1;
         else step();
      end
      chk("reset_reach", 32'(found), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_reset_idle", 32'(busy_o), 32'd0);
      end

      // Start pulses during SHIFT and DONE must not start another glyph
      run_glyph(4'd4, 0, 16'hA5C3, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
